mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit. It consumes the memory-control bundle the decode stage produces and turns it into a byte-enabled request/acknowledge transaction on the data-memory port.
- Loaded data is lane-aligned and sign- or zero-extended before return to writeback.
- Owns the LL/SC link reservation and stalls the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, maximum BUSY cycles without dmem_ack before abort. Used only with MEM_ACCESS_TIMEOUT_EN.
- TO_W, 8, width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- mem_valid  in  1  valid instruction occupies the MEM stage.
- mem_we  in  1  store (SW/SB/SH/SC).
- mem_read  in  1  load (LW/LB/LBU/LH/LL).
- mem_byte  in  1  byte access.
- mem_halfword  in  1  halfword access.
- mem_signextend  in  1  sign-extend sub-word load.
- mem_ll  in  1  load-linked.
- mem_sc  in  1  store-conditional.
- mem_addr  in  32  effective byte address (ALU result).
- mem_wdata  in  32  store data (rt).
- link_clear  in  1  external reservation kill (exception/ERET).
- mem_rdata  out  32  extended load data, or {31'b0, sc_success} for SC.
- mem_stall  out  1  hold the pipeline.
- addr_error  out  1  misaligned-access pulse.
- bus_error  out  1  timeout pulse; constant 0 without the macro.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write request.
- dmem_be  out  4  byte enables; bit i = byte lane i.
- dmem_addr  out  32  word-aligned address, with [1:0] = 0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  one-cycle completion.

Behaviour:
- Memory is little-endian; byte lane = addr[1:0].
- **Reset:** state=IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; mem_rdata=0; link_valid=0; link_addr=0; addr_error=0; bus_error=0. Reset asserted mid-transaction abandons the request immediately and clears the link.
- **Accesses:** acc = mem_valid & (mem_read|mem_we).
- **Misalignment:** mis = (halfword & addr[0]) | (word & |addr[1:0]).
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - acc & mis: pulse addr_error (registered, 1 cycle). No bus request. No stall beyond that cycle. Link unchanged.
  - acc & mem_sc & ~(link_valid & link_addr==addr[31:2]): SC fails. mem_rdata=0, no stall, no bus request.
  - Any other acc: register dmem_req=1 plus all request fields, then go to BUSY.
- **BUSY:** request fields are held stable until dmem_ack is sampled high. On ack:
  - capture aligned/extended read data (or 1 for SC) into mem_rdata;
  - drop dmem_req;
  - go to DONE.
- **DONE:** mem_stall=0 for exactly one cycle, so the pipeline advances; then go to IDLE.
- **mem_stall:** equals acc & ~mis & ~sc_fail & (state != DONE). The pipeline holds all inputs stable while stalled.
- **Latency:** minimum 3 cycles (IDLE, BUSY with same-cycle ack, DONE).
- **Store data:** byte = {4{wdata[7:0]}}, be = 1<<addr[1:0]; halfword = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011; word: be = 4'b1111.
- **Load extension:** byte/halfword are taken from the selected lane, then sign-extended if mem_signextend, else zero-extended.
- **Link register:**
  - LL completion sets link_valid=1 and link_addr=addr[31:2].
  - Any completed store (including a successful SC) whose word matches link_addr clears link_valid.
  - link_clear clears link_valid. If link_clear coincides with an LL completion, the clear wins.
  - A new LL overwrites the old link.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- When defined: a TO_W-bit counter increments on each BUSY cycle without ack. Reaching TIMEOUT_CYCLES:
  - drops dmem_req;
  - pulses bus_error;
  - sets mem_rdata=0;
  - goes to DONE;
  - leaves the link unchanged.
- When undefined: no counter; BUSY waits indefinitely; bus_error is tied 0.

Decomposition:
- Package mem_access_pkg holds:
  - FSM state enum;
  - byte-enable constants BE_WORD, BE_HALF_LO, BE_HALF_HI;
  - width localparams.
- One sub-module, mem_lane_align (combinational): lane select plus sign/zero extension of dmem_rdata.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> be=4'hF, dmem_addr=0x100; stall for 3 cycles; mem_rdata=0xDEADBEEF.
- LB addr 0x103, rdata 0x80123456, signextend=1 -> mem_rdata=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD -> be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1.
- LL 0x300 then SC 0x300 -> SC issues a write, mem_rdata=1. Repeated SC -> no dmem_req, mem_rdata=0, no stall.
- LL 0x300, SW 0x300, SC 0x300 -> SC fails. LL 0x300, link_clear pulse, SC -> fails.
- LW addr 0x102 -> addr_error pulse, no dmem_req. With macro and no ack: bus_error after 255 BUSY cycles. rst_n low in BUSY -> dmem_req=0 asynchronously.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
package mem_access_pkg;

  localparam int unsigned DataW     = 32;
  localparam int unsigned BeW       = 4;
  localparam int unsigned WordAddrW = 30;

  localparam logic [BeW-1:0] BE_WORD    = 4'b1111;
  localparam logic [BeW-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BeW-1:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it to 32 bits.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [DataW-1:0] rdata_i,
  input  logic [1:0]       lane_i,
  input  logic             byte_i,
  input  logic             half_i,
  input  logic             sext_i,
  output logic [DataW-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by sign or zero extension.
  always_comb begin
    unique case (lane_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    if (byte_i) begin
      data_o = {{24{sext_i & byte_v[7]}}, byte_v};
    end else if (half_i) begin
      data_o = {{16{sext_i & half_v[15]}}, half_v};
    end else begin
      data_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: byte-enabled req/ack data-memory transactions,
// load lane alignment, and the LL/SC link reservation.
// Optional bus timeout abort is enabled with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic             mem_we,
  input  logic             mem_read,
  input  logic             mem_byte,
  input  logic             mem_halfword,
  input  logic             mem_signextend,
  input  logic             mem_ll,
  input  logic             mem_sc,
  input  logic [DataW-1:0] mem_addr,
  input  logic [DataW-1:0] mem_wdata,
  input  logic             link_clear,
  output logic [DataW-1:0] mem_rdata,
  output logic             mem_stall,
  output logic             addr_error,
  output logic             bus_error,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [BeW-1:0]   dmem_be,
  output logic [DataW-1:0] dmem_addr,
  output logic [DataW-1:0] dmem_wdata,
  input  logic [DataW-1:0] dmem_rdata,
  input  logic             dmem_ack
);

  state_e               state_q, state_d;
  logic                 req_q, req_d, we_q, we_d;
  logic [BeW-1:0]       be_q, be_d, be_sel;
  logic [DataW-1:0]     addr_q, addr_d, wdata_q, wdata_d, wdata_sel;
  logic [DataW-1:0]     rdata_q, rdata_d, load_data;
  logic                 link_valid_q, link_valid_d;
  logic [WordAddrW-1:0] link_addr_q, link_addr_d;
  logic                 addr_err_q, addr_err_d;
  logic                 is_word, acc, mis, sc_fail, store_hits_link, end_req;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            bus_err_q, bus_err_d;
`endif

  assign is_word         = ~mem_byte & ~mem_halfword;
  assign acc             = mem_valid & (mem_read | mem_we);
  assign mis             = (mem_halfword & mem_addr[0]) | (is_word & (|mem_addr[1:0]));
  assign sc_fail         = acc & mem_sc &
                           ~(link_valid_q & (link_addr_q == mem_addr[DataW-1:2]));
  assign store_hits_link = link_valid_q & (link_addr_q == addr_q[DataW-1:2]);
  assign mem_stall       = acc & ~mis & ~sc_fail & (state_q != StDone);

  mem_lane_align u_lane_align (
    .rdata_i (dmem_rdata),
    .lane_i  (mem_addr[1:0]),
    .byte_i  (mem_byte),
    .half_i  (mem_halfword),
    .sext_i  (mem_signextend),
    .data_o  (load_data)
  );

  // Byte enables and lane-replicated store data for the addressed access size.
  always_comb begin
    if (mem_byte) begin
      be_sel    = 4'b0001 << mem_addr[1:0];
      wdata_sel = {4{mem_wdata[7:0]}};
    end else if (mem_halfword) begin
      be_sel    = mem_addr[1] ? BE_HALF_HI : BE_HALF_LO;
      wdata_sel = {2{mem_wdata[15:0]}};
    end else begin
      be_sel    = BE_WORD;
      wdata_sel = mem_wdata;
    end
  end

  // Next-state for the access FSM, request fields, load result and link.
  // MEM-stage inputs are held stable by the stall while BUSY, so they are used directly.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    addr_err_d   = 1'b0;
    end_req      = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    bus_err_d    = 1'b0;
    to_cnt_d     = (state_q == StBusy) ? to_cnt_q : '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (acc) begin
          if (mis) begin
            addr_err_d = 1'b1;
          end else if (sc_fail) begin
            rdata_d = '0;
          end else begin
            req_d   = 1'b1;
            we_d    = mem_we;
            be_d    = be_sel;
            addr_d  = {mem_addr[DataW-1:2], 2'b00};
            wdata_d = mem_we ? wdata_sel : '0;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (dmem_ack) begin
          end_req = 1'b1;
          if (mem_sc) begin
            rdata_d = DataW'(1);
          end else if (mem_read) begin
            rdata_d = load_data;
          end
          if (mem_ll) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_q[DataW-1:2];
          end
          if (mem_we && store_hits_link) begin
            link_valid_d = 1'b0;
          end
          state_d = StDone;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          end_req   = 1'b1;
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (end_req) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      be_d    = '0;
      addr_d  = '0;
      wdata_d = '0;
    end
    // An external kill beats a same-cycle LL completion.
    if (link_clear) begin
      link_valid_d = 1'b0;
    end
  end

  // State registers; reset abandons any outstanding request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      addr_err_q   <= addr_err_d;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // Timeout counter and bus-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_error = bus_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TO_W};
  assign bus_error          = 1'b0;
`endif

  assign mem_rdata  = rdata_q;
  assign addr_error = addr_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// loads/stores/LL/SC checked against a byte-addressed memory and link model.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        mem_valid, mem_we, mem_read, mem_byte, mem_halfword, mem_signextend;
  logic        mem_ll, mem_sc, link_clear, dmem_ack;
  logic [31:0] mem_addr, mem_wdata, dmem_rdata;
  logic [31:0] mem_rdata, dmem_addr, dmem_wdata;
  logic        mem_stall, addr_error, bus_error, dmem_req, dmem_we;
  logic [3:0]  dmem_be;

  mem_access_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_we         (mem_we),
    .mem_read       (mem_read),
    .mem_byte       (mem_byte),
    .mem_halfword   (mem_halfword),
    .mem_signextend (mem_signextend),
    .mem_ll         (mem_ll),
    .mem_sc         (mem_sc),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .link_clear     (link_clear),
    .mem_rdata      (mem_rdata),
    .mem_stall      (mem_stall),
    .addr_error     (addr_error),
    .bus_error      (bus_error),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_be        (dmem_be),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {LW, LB, LBU, LH, LHU, SW, SB, SH, LL, SC} kind_e;
  typedef struct packed {
    logic        we, rd, byt, half, sext, ll, sc;
    logic [31:0] addr, wdata;
  } op_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: byte memory, link reservation, mem_rdata register.
  logic [7:0]  mem_b [0:1023];
  bit          m_lv;
  logic [29:0] m_lw;
  logic [31:0] m_rd;
  bit          e_issue, e_mis;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;
  int          e_stall;

  // Observations from the last transaction.
  int          obs_req, obs_stall, obs_berr;
  bit          obs_unstable, obs_we, obs_aerr;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;

  function automatic op_t mk(input kind_e k, input logic [31:0] a, input logic [31:0] wd);
    op_t o;
    o       = '0;
    o.addr  = a;
    o.wdata = wd;
    o.rd    = k inside {LW, LB, LBU, LH, LHU, LL};
    o.we    = k inside {SW, SB, SH, SC};
    o.byt   = k inside {LB, LBU, SB};
    o.half  = k inside {LH, LHU, SH};
    o.sext  = k inside {LB, LH};
    o.ll    = (k == LL);
    o.sc    = (k == SC);
    return o;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int unsigned b;
    b = a & 32'h3FC;
    return {mem_b[b+3], mem_b[b+2], mem_b[b+1], mem_b[b]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem_b[(a & 32'h3FC) + i] = v[8*i +: 8];
  endtask

  // Predict the outcome of one access from the architectural rules and update the model.
  task automatic model_op(input op_t o, input int ack_dly);
    int          n;
    int unsigned a;
    logic [31:0] v;
    n       = o.byt ? 1 : (o.half ? 2 : 4);
    a       = o.addr;
    e_mis   = (a % n) != 0;
    e_issue = !e_mis && !(o.sc && !(m_lv && m_lw == o.addr[31:2]));
    e_be    = 4'(((1 << n) - 1) << (a % 4));
    e_addr  = o.addr & ~32'h3;
    for (int k = 0; k < 4; k++) e_wdata[8*k +: 8] = o.wdata[8*(k % n) +: 8];
    e_stall = e_issue ? ack_dly + 1 : 0;
    if (!e_mis) begin
      if (!e_issue) begin
        m_rd = '0;
      end else if (o.sc) begin
        m_rd = 32'd1;
      end else if (o.rd) begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_b[(a + i) & 1023]) << (8 * i));
        if (o.sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        m_rd = v;
      end
    end
    if (e_issue && o.we) begin
      for (int i = 0; i < n; i++) mem_b[(a + i) & 1023] = o.wdata[8*i +: 8];
      if (m_lv && m_lw == o.addr[31:2]) m_lv = 0;
    end
    if (e_issue && o.ll) begin
      m_lv = 1;
      m_lw = o.addr[31:2];
    end
  endtask

  // Present one instruction, act as the memory (ack in BUSY cycle ack_dly; 0 = never),
  // and hold it until the pipeline is released.
  task automatic run_op(input op_t o, input int ack_dly);
    int cyc, busy;
    bit done, stall_now;
    @(posedge clk); #1;
    {mem_we, mem_read, mem_byte, mem_halfword, mem_signextend, mem_ll, mem_sc} =
      {o.we, o.rd, o.byt, o.half, o.sext, o.ll, o.sc};
    mem_addr  = o.addr;
    mem_wdata = o.wdata;
    mem_valid = 1'b1;
    obs_req = 0; obs_stall = 0; obs_berr = 0; obs_unstable = 0;
    cyc = 0; busy = 0; done = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      stall_now = mem_stall;
      if (mem_stall) obs_stall++;
      if (bus_error) obs_berr++;
      if (dmem_req) begin
        if (obs_req == 0) begin
          {obs_we, obs_be, obs_addr, obs_wdata} = {dmem_we, dmem_be, dmem_addr, dmem_wdata};
        end else if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !==
                     {obs_we, obs_be, obs_addr, obs_wdata}) begin
          obs_unstable = 1;
        end
        obs_req++;
        busy++;
        if (busy == ack_dly) begin
          dmem_ack   = 1'b1;
          dmem_rdata = mem_word(o.addr);
        end
      end
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (!stall_now) done = 1;
      cyc++;
    end
    mem_valid = 0; mem_we = 0; mem_read = 0; mem_byte = 0; mem_halfword = 0;
    mem_signextend = 0; mem_ll = 0; mem_sc = 0; mem_addr = '0; mem_wdata = '0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_bound: stall still high after %0d cycles, required release", cyc);
    end
    @(negedge clk);
    obs_aerr  = addr_error;
    obs_rdata = mem_rdata;
  endtask

  task automatic go(input op_t o, input int ack_dly);
    model_op(o, ack_dly);
    run_op(o, ack_dly);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    link_clear = 1'b1;
    @(posedge clk); #1;
    link_clear = 1'b0;
    m_lv = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: got req=%b we=%b be=%h addr=%h wdata=%h, required all 0",
               dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
    end
    n_cmp++;
    if ({mem_rdata, addr_error, bus_error, mem_stall} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: got rdata=%h aerr=%b berr=%b stall=%b, required all 0",
               mem_rdata, addr_error, bus_error, mem_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    set_word(32'h100, 32'hDEAD_BEEF);
    go(mk(LW, 32'h100, 0), 2);
    n_cmp++;
    if (obs_be !== 4'hF || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
      n_bad++;
      $display("FAIL lw_req: got be=%h addr=%h we=%b, required be=f addr=00000100 we=0",
               obs_be, obs_addr, obs_we);
    end
    n_cmp++;
    if (obs_stall !== 3) begin
      n_bad++; $display("FAIL lw_stall: got %0d cycles, required 3", obs_stall);
    end
    n_cmp++;
    if (obs_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL lw_rdata: got %h, required deadbeef", obs_rdata);
    end
  endtask

  task automatic test_byte_ext();
    set_word(32'h100, 32'h8012_3456);
    go(mk(LB, 32'h103, 0), 1);
    n_cmp++;
    if (obs_rdata !== 32'hFFFF_FF80 || obs_be !== 4'b1000) begin
      n_bad++;
      $display("FAIL lb_sext: got rdata=%h be=%h, required ffffff80 be=8", obs_rdata, obs_be);
    end
    go(mk(LBU, 32'h103, 0), 1);
    n_cmp++;
    if (obs_rdata !== 32'h0000_0080) begin
      n_bad++; $display("FAIL lbu_zext: got %h, required 00000080", obs_rdata);
    end
  endtask

  task automatic test_store_half();
    go(mk(SH, 32'h202, 32'h0000_ABCD), 1);
    n_cmp++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1 ||
        obs_addr !== 32'h200) begin
      n_bad++;
      $display("FAIL sh_req: got be=%h wdata=%h we=%b addr=%h, required c abcdabcd 1 00000200",
               obs_be, obs_wdata, obs_we, obs_addr);
    end
  endtask

  task automatic test_ll_sc();
    go(mk(LL, 32'h300, 0), 1);
    go(mk(SC, 32'h300, 32'h1234_5678), 1);
    n_cmp++;
    if (obs_req !== 1 || obs_we !== 1'b1 || obs_rdata !== 32'd1) begin
      n_bad++;
      $display("FAIL sc_ok: got req_cycles=%0d we=%b rdata=%h, required 1 1 00000001",
               obs_req, obs_we, obs_rdata);
    end
    go(mk(SC, 32'h300, 32'h1234_5678), 1);
    n_cmp++;
    if (obs_req !== 0 || obs_stall !== 0 || obs_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL sc_repeat: got req_cycles=%0d stall=%0d rdata=%h, required 0 0 0",
               obs_req, obs_stall, obs_rdata);
    end
  endtask

  task automatic test_link_kill();
    go(mk(LL, 32'h300, 0), 1);
    go(mk(SW, 32'h300, 32'hCAFE_0001), 1);
    go(mk(SC, 32'h300, 32'h5), 1);
    n_cmp++;
    if (obs_req !== 0 || obs_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL sc_after_sw: got req_cycles=%0d rdata=%h, required 0 0", obs_req, obs_rdata);
    end
    go(mk(LL, 32'h300, 0), 1);
    pulse_clear();
    go(mk(SC, 32'h300, 32'h6), 1);
    n_cmp++;
    if (obs_req !== 0 || obs_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL sc_after_clear: got req_cycles=%0d rdata=%h, required 0 0",
               obs_req, obs_rdata);
    end
    // link_clear held across an LL completion must win.
    link_clear = 1'b1;
    go(mk(LL, 32'h300, 0), 2);
    link_clear = 1'b0;
    m_lv = 0;
    go(mk(SC, 32'h300, 32'h7), 1);
    n_cmp++;
    if (obs_req !== 0) begin
      n_bad++; $display("FAIL clear_beats_ll: got req_cycles=%0d, required 0", obs_req);
    end
  endtask

  task automatic test_misaligned();
    go(mk(LW, 32'h102, 0), 1);
    n_cmp++;
    if (obs_aerr !== 1'b1 || obs_req !== 0 || obs_stall !== 0) begin
      n_bad++;
      $display("FAIL lw_misaligned: got aerr=%b req_cycles=%0d stall=%0d, required 1 0 0",
               obs_aerr, obs_req, obs_stall);
    end
    @(negedge clk);
    n_cmp++;
    if (addr_error !== 1'b0) begin
      n_bad++; $display("FAIL aerr_pulse: got %b one cycle later, required 0", addr_error);
    end
  endtask

  task automatic test_async_reset();
    go(mk(LL, 32'h340, 0), 1);
    @(posedge clk); #1;
    mem_read  = 1'b1;
    mem_addr  = 32'h344;
    mem_valid = 1'b1;
    @(posedge clk); #3;
    n_cmp++;
    if (dmem_req !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre_req: got %b, required 1", dmem_req);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dmem_req !== 1'b0 || dmem_be !== 4'h0 || mem_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_async: got req=%b be=%h rdata=%h, required 0 0 0",
               dmem_req, dmem_be, mem_rdata);
    end
    mem_valid = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    m_lv = 0;
    m_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    go(mk(SC, 32'h340, 32'h9), 1);
    n_cmp++;
    if (obs_req !== 0) begin
      n_bad++; $display("FAIL rst_link: SC got req_cycles=%0d, required 0", obs_req);
    end
  endtask

  task automatic test_random();
    op_t         o;
    kind_e       k;
    int          d, n;
    logic [31:0] a;
    for (int t = 0; t < 60; t++) begin
      k = kind_e'($urandom_range(0, 9));
      o = mk(k, 32'h0, $urandom);
      n = o.byt ? 1 : (o.half ? 2 : 4);
      a = 32'h300 + 32'($urandom_range(0, 23));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
      o.addr = a;
      d = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) pulse_clear();
      go(o, d);
      n_cmp++;
      if (obs_req !== (e_issue ? d : 0) || obs_stall !== e_stall) begin
        n_bad++;
        $display("FAIL rnd%0d_timing: got req_cycles=%0d stall=%0d, required %0d %0d",
                 t, obs_req, obs_stall, e_issue ? d : 0, e_stall);
      end
      n_cmp++;
      if (obs_aerr !== e_mis || obs_berr !== 0 || obs_unstable !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd%0d_flags: got aerr=%b berr=%0d unstable=%b, required %b 0 0",
                 t, obs_aerr, obs_berr, obs_unstable, e_mis);
      end
      n_cmp++;
      if (obs_rdata !== m_rd) begin
        n_bad++; $display("FAIL rnd%0d_rdata: got %h, required %h", t, obs_rdata, m_rd);
      end
      if (e_issue) begin
        n_cmp++;
        if (obs_be !== e_be || obs_addr !== e_addr || obs_we !== o.we ||
            (o.we && obs_wdata !== e_wdata)) begin
          n_bad++;
          $display("FAIL rnd%0d_req: got be=%h addr=%h we=%b wd=%h, required %h %h %b %h",
                   t, obs_be, obs_addr, obs_we, obs_wdata, e_be, e_addr, o.we, e_wdata);
        end
      end
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    run_op(mk(LW, 32'h104, 0), 0);
    m_rd = '0;
    n_cmp++;
    if (obs_req !== 255 || obs_stall !== 256 || obs_berr !== 1 || obs_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL timeout: got req=%0d stall=%0d berr=%0d rdata=%h, required 255 256 1 0",
               obs_req, obs_stall, obs_berr, obs_rdata);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {mem_valid, mem_we, mem_read, mem_byte, mem_halfword, mem_signextend} = '0;
    {mem_ll, mem_sc, link_clear, dmem_ack} = '0;
    mem_addr = '0; mem_wdata = '0; dmem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
    m_lv = 0; m_lw = '0; m_rd = '0;
    test_reset();
    test_lw();
    test_byte_ext();
    test_store_half();
    test_ll_sc();
    test_link_kill();
    test_misaligned();
    test_async_reset();
    test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
